// File: rtl/mbram_pkg.sv
// Shared constants and lane-slicing helpers for the multi-bank dual-port RAM.
package mbram_pkg;

    localparam int unsigned MAX_RD_LATENCY = 4;
    localparam int unsigned MAX_NUM_BANKS  = 64;

    // Base bit index of lane b inside a packed per-bank address bus.
    function automatic int unsigned addr_lane(input int unsigned b, input int unsigned addr_width);
        return b * addr_width;
    endfunction

    // Base bit index of lane b inside a packed per-bank data bus.
    function automatic int unsigned data_lane(input int unsigned b, input int unsigned data_width);
        return b * data_width;
    endfunction

endpackage

// File: rtl/mbram_bank.sv
// Single 1R1W bank with a read-first array register and a data/valid output pipeline.
// With MBRAM_PINGPONG_EN defined the bank holds two pages: reads use page, writes use ~page.
module mbram_bank
    import mbram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  page,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

`ifdef MBRAM_PINGPONG_EN
    localparam int unsigned PA_WIDTH = ADDR_WIDTH + 1;
`else
    localparam int unsigned PA_WIDTH = ADDR_WIDTH;
`endif
    localparam int unsigned DEPTH = 1 << PA_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } pipe_entry_t;

    logic [PA_WIDTH-1:0]   wpa;
    logic [PA_WIDTH-1:0]   rpa;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    pipe_entry_t           pipe [RD_LATENCY];

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("mbram_bank: RD_LATENCY must be in 1..4");
    end

`ifdef MBRAM_PINGPONG_EN
    assign wpa = {~page, waddr};
    assign rpa = {page, raddr};
`else
    logic page_unused;
    assign page_unused = page;
    assign wpa = waddr;
    assign rpa = raddr;
`endif

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wpa] <= din;
        end
    end

    // Stage 0 is the array read register (read-first); later stages only shift, holding data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= ren;
            if (ren) begin
                pipe[0].data <= mem[rpa];
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe[i].valid <= pipe[i-1].valid;
                if (pipe[i-1].valid) begin
                    pipe[i].data <= pipe[i-1].data;
                end
            end
        end
    end

    assign dout       = pipe[RD_LATENCY-1].data;
    assign dout_valid = pipe[RD_LATENCY-1].valid;

endmodule

// File: rtl/multi_bank_ram_dp.sv
// NUM_BANKS independent 1R1W banks with a pipelined read path and per-lane valid strobes.
// Optional ping-pong paging is enabled by defining MBRAM_PINGPONG_EN.
module multi_bank_ram_dp
    import mbram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_BANKS-1:0]             wen,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  waddr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  din,
    input  logic [NUM_BANKS-1:0]             ren,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  raddr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  dout,
    output logic [NUM_BANKS-1:0]             dout_valid,
    input  logic                             swap,
    output logic                             page
);

    logic                 page_q;
    logic [NUM_BANKS-1:0] wen_g;
    logic [NUM_BANKS-1:0] ren_g;

    if (NUM_BANKS < 1 || NUM_BANKS > MAX_NUM_BANKS) begin : g_bad_banks
        $error("multi_bank_ram_dp: NUM_BANKS must be in 1..64");
    end

    // No array access is issued while reset is held.
    assign wen_g = rst ? '0 : wen;
    assign ren_g = rst ? '0 : ren;

`ifdef MBRAM_PINGPONG_EN
    // Page toggles on swap and takes effect for accesses sampled on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            page_q <= 1'b0;
        end else if (swap) begin
            page_q <= ~page_q;
        end
    end
`else
    logic swap_unused;
    assign swap_unused = swap;
    assign page_q      = 1'b0;
`endif

    assign page = page_q;

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        mbram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .RD_LATENCY (RD_LATENCY)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .wen        (wen_g[b]),
            .waddr      (waddr[addr_lane(b, ADDR_WIDTH) +: ADDR_WIDTH]),
            .din        (din[data_lane(b, DATA_WIDTH) +: DATA_WIDTH]),
            .ren        (ren_g[b]),
            .raddr      (raddr[addr_lane(b, ADDR_WIDTH) +: ADDR_WIDTH]),
            .page       (page_q),
            .dout       (dout[data_lane(b, DATA_WIDTH) +: DATA_WIDTH]),
            .dout_valid (dout_valid[b])
        );
    end

endmodule

// File: tb/tb_multi_bank_ram_dp.sv
// Directed and reference-model checks for multi_bank_ram_dp at RD_LATENCY 1, 2 and 4.
module tb_multi_bank_ram_dp;

    localparam int unsigned DW   = 28;
    localparam int unsigned AW   = 5;
    localparam int unsigned NB   = 4;
    localparam int          NCYC = 300;
`ifdef MBRAM_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     wen, ren;
    logic [NB*AW-1:0]  waddr, raddr;
    logic [NB*DW-1:0]  din;
    logic              swap;
    logic [NB*DW-1:0]  dout1, dout2, dout4;
    logic [NB-1:0]     dv1, dv2, dv4;
    logic              page1, page2, page4;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mmem  [NB][64];
    bit            hren  [NB][NCYC];
    logic [DW-1:0] hrd   [NB][NCYC];
    logic [DW-1:0] lastd [3][NB];
    int            lat   [3] = '{1, 2, 4};
    bit            mpage;

    always #5 clk = ~clk;

    multi_bank_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .din(din), .ren(ren), .raddr(raddr),
        .dout(dout2), .dout_valid(dv2), .swap(swap), .page(page2));
    multi_bank_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .din(din), .ren(ren), .raddr(raddr),
        .dout(dout1), .dout_valid(dv1), .swap(swap), .page(page1));
    multi_bank_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .din(din), .ren(ren), .raddr(raddr),
        .dout(dout4), .dout_valid(dv4), .swap(swap), .page(page4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen  = '0;
        ren  = '0;
        swap = 1'b0;
    endtask

    task automatic wr(input int b, input int a, input logic [DW-1:0] d);
        wen[b]             = 1'b1;
        waddr[b*AW +: AW]  = AW'(a);
        din[b*DW +: DW]    = d;
    endtask

    task automatic rd(input int b, input int a);
        ren[b]             = 1'b1;
        raddr[b*AW +: AW]  = AW'(a);
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane2(input int b);
        return dout2[b*DW +: DW];
    endfunction

    task automatic flip();
        if (PP) begin
            swap = 1'b1;
            step();
            swap = 1'b0;
        end
    endtask

    // Applies the current inputs at the next edge to the model, then compares every instance.
    task automatic model_edge(input int e);
        int                pa, idx;
        logic [NB-1:0]     ev, gv;
        logic [NB*DW-1:0]  ed, gd;
        for (int b = 0; b < int'(NB); b++) begin
            hren[b][e] = ren[b];
            pa = ((PP && mpage) ? 32 : 0) + int'(raddr[b*AW +: AW]);
            if (ren[b]) hrd[b][e] = mmem[b][pa];
        end
        for (int b = 0; b < int'(NB); b++) begin
            pa = ((PP && !mpage) ? 32 : 0) + int'(waddr[b*AW +: AW]);
            if (wen[b]) mmem[b][pa] = din[b*DW +: DW];
        end
        if (PP && swap) mpage = !mpage;
        step();
        for (int li = 0; li < 3; li++) begin
            ev = '0;
            for (int b = 0; b < int'(NB); b++) begin
                idx = e - lat[li] + 1;
                if (idx >= 0 && hren[b][idx]) begin
                    ev[b]        = 1'b1;
                    lastd[li][b] = hrd[b][idx];
                end
                ed[b*DW +: DW] = lastd[li][b];
            end
            case (li)
                0:       begin gv = dv1; gd = dout1; end
                1:       begin gv = dv2; gd = dout2; end
                default: begin gv = dv4; gd = dout4; end
            endcase
            chk($sformatf("rand_L%0d_valid_e%0d", lat[li], e), 128'(gv), 128'(ev));
            chk($sformatf("rand_L%0d_data_e%0d", lat[li], e), 128'(gd), 128'(ed));
        end
        chk($sformatf("rand_page_e%0d", e), 128'({page1, page2, page4}), 128'({3{mpage}}));
    endtask

    initial begin
        logic [NB*DW-1:0] exp_d;
        idle();
        waddr = '0;
        raddr = '0;
        din   = '0;
        rst   = 1'b1;
        step();
        step();
        chk("reset_dout", 128'(dout2), 128'(0));
        chk("reset_valid", 128'(dv2), 128'(0));
        chk("reset_page", 128'(page2), 128'(0));
        rst = 1'b0;

        // Write then read one word on bank 0.
        wr(0, 3, 28'h0ABCDEF);
        step();
        idle();
        flip();
        rd(0, 3);
        step();
        idle();
        chk("t1_not_yet", 128'(dv2), 128'(0));
        step();
        chk("t1_valid", 128'(dv2), 128'(4'b0001));
        chk("t1_data", 128'(lane2(0)), 128'(28'h0ABCDEF));
        step();
        chk("t1_valid_drop", 128'(dv2), 128'(0));
        chk("t1_hold", 128'(lane2(0)), 128'(28'h0ABCDEF));

        // Preload all banks, then back-to-back reads.
        for (int a = 0; a < 32; a++) begin
            idle();
            for (int b = 0; b < int'(NB); b++) wr(b, a, DW'(b * 256 + a));
            step();
        end
        idle();
        flip();
        for (int i = 0; i <= 32; i++) begin
            idle();
            if (i < 32) for (int b = 0; b < int'(NB); b++) rd(b, i);
            step();
            if (i == 0) begin
                chk("t2_first_gap", 128'(dv2), 128'(0));
            end else begin
                for (int b = 0; b < int'(NB); b++) exp_d[b*DW +: DW] = DW'(b * 256 + i - 1);
                chk($sformatf("t2_valid_%0d", i - 1), 128'(dv2), 128'(4'hF));
                chk($sformatf("t2_data_%0d", i - 1), 128'(dout2), 128'(exp_d));
            end
        end
        idle();
        step();
        chk("t2_end_valid", 128'(dv2), 128'(0));
        chk("t2_lane3_hold", 128'(lane2(3)), 128'(28'h31F));

`ifdef MBRAM_PINGPONG_EN
        // Write lands in the idle page; a write in the swap cycle also uses the pre-swap page.
        wr(0, 5, 28'h55);
        step();
        idle();
        swap = 1'b1;
        wr(0, 6, 28'h66);
        step();
        idle();
        chk("pp_page", 128'(page2), 128'(1));
        rd(0, 5);
        step();
        idle();
        rd(0, 6);
        step();
        idle();
        chk("pp_valid_a", 128'(dv2), 128'(4'b0001));
        chk("pp_data_a", 128'(lane2(0)), 128'(28'h55));
        step();
        chk("pp_data_b", 128'(lane2(0)), 128'(28'h66));
`else
        // Same-address read and write in one cycle returns the old word.
        wr(2, 7, 28'h11);
        step();
        idle();
        wr(2, 7, 28'h22);
        rd(2, 7);
        step();
        idle();
        rd(2, 7);
        step();
        idle();
        chk("coll_valid", 128'(dv2), 128'(4'b0100));
        chk("coll_old", 128'(lane2(2)), 128'(28'h11));
        step();
        chk("coll_new", 128'(lane2(2)), 128'(28'h22));
`endif

        // Reset with reads in flight, and a write attempted during reset.
        idle();
        rd(0, 1);
        rd(1, 2);
        rd(2, 3);
        step();
        idle();
        rst = 1'b1;
        wr(1, 0, 28'hDEAD);
        rd(3, 4);
        step();
        chk("rst_valid_a", 128'(dv2), 128'(0));
        chk("rst_dout", 128'(dout2), 128'(0));
        chk("rst_page", 128'(page2), 128'(0));
        step();
        chk("rst_valid_b", 128'(dv2), 128'(0));
        rst = 1'b0;
        idle();
        step();
        chk("rst_valid_c", 128'(dv2), 128'(0));
        step();
        chk("rst_valid_d", 128'(dv2), 128'(0));
        chk("rst_dout_after", 128'(dout2), 128'(0));
        rd(1, 0);
        step();
        idle();
        step();
        chk("rst_no_write_valid", 128'(dv2), 128'(4'b0010));
        chk("rst_no_write_data", 128'(lane2(1)), 128'(256));

        // Random traffic against the reference model on all three latencies.
        idle();
        rst = 1'b1;
        step();
        step();
        rst   = 1'b0;
        mpage = 1'b0;
        for (int li = 0; li < 3; li++)
            for (int b = 0; b < int'(NB); b++) lastd[li][b] = '0;
        for (int e = 0; e < NCYC; e++) begin
            idle();
            if (e < 64) begin
                for (int b = 0; b < int'(NB); b++) wr(b, e % 32, DW'($urandom));
                swap = (e == 31);
            end else if (e < NCYC - 4) begin
                wen   = NB'($urandom);
                ren   = NB'($urandom);
                waddr = (NB*AW)'($urandom);
                raddr = (NB*AW)'($urandom);
                for (int b = 0; b < int'(NB); b++) din[b*DW +: DW] = DW'($urandom);
                swap  = ($urandom_range(0, 7) == 0);
            end
            model_edge(e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
